// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 4-entry fully associative read-only cache
// with 2-bit LRU counters; owns entry state and drives the memory fill handshake.
module cache_ctrl #(
  parameter int a_width = 8,
  parameter int d_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_req,
  input  logic [a_width-1:0]     cpu_addr,
  output logic [d_width-1:0]     cpu_rdata,
  output logic                   cpu_ready,
  input  logic                   flush,
  output logic                   busy,
  output logic [a_width-1:0]     lookup_addr,
  output logic [4*a_width-1:0]   w_entry_addrs,
  output logic [7:0]             w_cnt,
  output logic [3:0]             valid,
  input  logic                   hit,
  input  logic [1:0]             sel,
  input  logic [3:0]             dec,
  output logic                   mem_req,
  output logic [a_width-1:0]     mem_addr,
  input  logic                   mem_ack,
  input  logic [d_width-1:0]     mem_data
);
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;
  state_t state, state_n;
  logic [d_width-1:0] data [4];
  logic [1:0] victim, usel;
  logic [3:0] dec_r, udec;
  logic [7:0] cnt_n;
  logic upd;
  assign busy = state != IDLE;
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // A fill reuses the LRU update of a hit, but with the victim and dec captured at the miss.
  always_comb begin
    state_n = state == IDLE ? ((!flush && cpu_req) ? LOOKUP : IDLE)
            : state == LOOKUP ? (hit ? IDLE : FILL)
            : (mem_ack ? IDLE : FILL);
    upd = (state == LOOKUP && hit) || (state == FILL && mem_ack);
    usel = state == LOOKUP ? sel : victim;
    udec = state == LOOKUP ? dec : dec_r;
    cnt_n = w_cnt;
    for (int i = 0; i < 4; i++)
      cnt_n[2*i +: 2] = usel == 2'(i) ? 2'd3
                      : (udec[i] && w_cnt[2*i +: 2] != 2'd0) ? w_cnt[2*i +: 2] - 2'd1
                      : w_cnt[2*i +: 2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      w_cnt <= '0;
      w_entry_addrs <= '0;
      for (int i = 0; i < 4; i++) data[i] <= '0;
      lookup_addr <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      victim <= '0;
      dec_r <= '0;
    end else begin
      cpu_ready <= upd;
      if (upd) begin
        cpu_rdata <= state == LOOKUP ? data[sel] : mem_data;
        w_cnt <= cnt_n;
      end
      if (state == IDLE && flush) begin
        valid <= '0;
        w_cnt <= '0;
      end
      if (state == IDLE && !flush && cpu_req) lookup_addr <= cpu_addr;
      if (state == LOOKUP && !hit) begin
        victim <= sel;
        dec_r <= dec;
        mem_addr <= lookup_addr;
        mem_req <= 1'b1;
      end
      if (state == FILL && mem_ack) begin
        mem_req <= 1'b0;
        data[victim] <= mem_data;
        w_entry_addrs[victim*a_width +: a_width] <= lookup_addr;
        valid[victim] <= 1'b1;
      end
    end
  end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Sequencing controller for the 4-entry fully associative, read-only cache with 2-bit LRU counters.
- Owns the entry address, valid, count and data registers.
- Presents them to the hit-determination logic and consumes its hit/sel/dec result.
- Services CPU read requests: 1-cycle lookup, then either hit return or a memory fill over a req/ack handshake.
- Sits between the CPU fetch/load port and the memory interface.

Parameters:
a_width, 8, address width (matches hit-logic address width)
d_width, 8, data word width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
cpu_req  input  1  CPU read request, sampled in IDLE
cpu_addr  input  a_width  CPU read address, sampled with cpu_req
cpu_rdata  output  d_width  read data, valid while cpu_ready=1
cpu_ready  output  1  1-cycle pulse: read complete
flush  input  1  invalidate all entries, sampled in IDLE
busy  output  1  1 when state != IDLE
lookup_addr  output  a_width  registered address driven to hit logic
w_entry_addrs  output  a_width*4  entry addresses, entry i at [(i+1)*a_width-1 : i*a_width]
w_cnt  output  8  LRU counts, entry i at [2i+1:2i]
valid  output  4  entry valid bits
hit  input  1  from hit logic: 1 = hit
sel  input  2  from hit logic: hit entry, or victim entry on miss
dec  input  4  from hit logic: counters to decrement
mem_req  output  1  memory read request
mem_addr  output  a_width  memory read address
mem_ack  input  1  memory data valid, 1-cycle pulse
mem_data  input  d_width  memory read data

Behaviour:
- Reset (synchronous, highest priority, any state):
  - state=IDLE; valid=0; all counts=0; all entry addrs=0; data array=0.
  - lookup_addr=0; cpu_ready=0; cpu_rdata=0; mem_req=0; mem_addr=0; busy=0.
  - Reset during FILL drops mem_req the next cycle. No CPU response is given.
- States: IDLE, LOOKUP, FILL.
- IDLE:
  - flush=1: valid<=0, all counts<=0. Stay IDLE. Takes 1 cycle and has priority over cpu_req.
  - else cpu_req=1: lookup_addr<=cpu_addr, go to LOOKUP.
- LOOKUP (hit inputs are combinational from lookup_addr, consumed this cycle):
  - hit=1:
    - cpu_rdata<=data[sel], cpu_ready<=1 (next cycle), go to IDLE.
    - cnt[sel]<=3; for each i!=sel with dec[i]=1, cnt[i]<=cnt[i]-1.
  - hit=0: latch victim=sel, mem_addr<=lookup_addr, mem_req<=1, go to FILL.
- FILL:
  - mem_req held 1 until the cycle mem_ack=1 is sampled. mem_req=0 from the following cycle.
  - On mem_ack:
    - data[victim]<=mem_data; entry_addr[victim]<=lookup_addr; valid[victim]<=1.
    - cnt[victim]<=3; for i!=victim with the dec bit captured in LOOKUP =1, cnt[i]<=cnt[i]-1.
    - cpu_rdata<=mem_data, cpu_ready<=1, go to IDLE.
  - The dec vector is registered at the LOOKUP miss; later changes on dec/sel inputs are ignored.
- Counter arithmetic: 2-bit, decrement saturates at 0, never wraps 0->3. The dec bit for the selected/victim entry is ignored.
- cpu_ready: exactly 1 cycle, in the cycle after the LOOKUP hit or the mem_ack. cpu_rdata holds its value until the next cpu_ready.
- Latency: hit = 2 cycles from cpu_req sampled to cpu_ready. Miss = 3 cycles + memory ack wait.
- Ignored inputs:
  - cpu_req and flush outside IDLE; the requester holds them.
  - mem_ack outside FILL.
  - Dropping cpu_req mid-FILL does not abort; the fill completes and cpu_ready still pulses.
- busy = (state != IDLE), combinational from state.

Test Plan:
1. Reset, then idle: valid=0000, w_cnt=0x00, mem_req=0, cpu_ready=0, busy=0.
2. Cold fills of 0x10, 0x20, 0x30, 0x40 (ack after 2 cycles, data 0xA1..0xA4):
   - each returns cpu_rdata = its data;
   - final state: valid=1111, cnt=(0,1,2,3), entry addrs 0x10/0x20/0x30/0x40.
3. Hit: read 0x20 after step 2 -> cpu_ready 2 cycles after request, rdata=0xA2, mem_req stays 0, cnt=(0,3,1,2).
4. LRU replacement: from step-2 state, read 0x50 (ack data 0xB5):
   - victim entry0, mem_addr=0x50;
   - after ack entry0 addr=0x50, cnt=(3,0,1,2);
   - a later read of 0x10 misses again.
5. Flush: flush=1 in IDLE with cpu_req=1 -> valid=0000, cnt=0x00, no lookup that cycle. The next read of 0x20 misses.
6. Reset mid-FILL:
   - reset asserted while mem_req=1 -> next cycle mem_req=0, IDLE, valid=0000, no cpu_ready.
   - a late mem_ack is ignored.
